// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all downstream resets, waits for PLL lock, then releases
// them one by one in index order with fixed spacing; restarts on sw request or lock loss.
module rst_seq_ctrl #(
    parameter int unsigned NUM_OUT     = 4,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned STEP_CYCLES = 8
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               pll_lock_i,
    input  logic               sw_rst_req_i,
    output logic [NUM_OUT-1:0] rstn_o,
    output logic               done_o,
    output logic               lock_lost_o
);

    localparam int unsigned MaxCycles = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);
    localparam int unsigned IdxW      = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
    localparam logic [CntW-1:0] StepLast = CntW'(STEP_CYCLES - 1);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(NUM_OUT - 1);

    if (HOLD_CYCLES == 0 || STEP_CYCLES == 0 || NUM_OUT < 1) begin : g_bad_params
        $error("rst_seq_ctrl: HOLD_CYCLES and STEP_CYCLES must be >= 1, NUM_OUT >= 1");
    end

    typedef enum logic [1:0] {
        StHold,
        StWaitLock,
        StRelease,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [NUM_OUT-1:0]  rstn_q, rstn_d;
    logic                done_q, done_d;
    logic                lost_q, lost_d;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= StHold;
            cnt_q   <= '0;
            idx_q   <= '0;
            rstn_q  <= '0;
            done_q  <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rstn_q  <= rstn_d;
            done_q  <= done_d;
            lost_q  <= lost_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rstn_d  = rstn_q;
        done_d  = done_q;
        lost_d  = lost_q;

        unique case (state_q)
            StHold: begin
                rstn_d = '0;
                done_d = 1'b0;
                if (sw_rst_req_i) begin
                    cnt_d = '0;
                end else if (cnt_q == HoldLast) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWaitLock: begin
                rstn_d = '0;
                done_d = 1'b0;
                if (sw_rst_req_i) begin
                    state_d = StHold;
                    cnt_d   = '0;
                end else if (pll_lock_i) begin
                    state_d = StRelease;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            StRelease, StDone: begin
                if (sw_rst_req_i || !pll_lock_i) begin
                    // All partially released outputs drop together on this edge.
                    state_d = StHold;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rstn_d  = '0;
                    done_d  = 1'b0;
                    if (!pll_lock_i) begin
                        lost_d = 1'b1;
                    end
                end else if (state_q == StRelease) begin
                    if (cnt_q == StepLast) begin
                        rstn_d[idx_q] = 1'b1;
                        cnt_d         = '0;
                        if (idx_q == IdxLast) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + IdxW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            default: begin
                state_d = StHold;
            end
        endcase
    end

    assign rstn_o      = rstn_q;
    assign done_o      = done_q;
    assign lock_lost_o = lost_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: default 4/16/8 instance plus a minimal 1/1/1 instance.
module tb_rst_seq_ctrl;

    logic       clk;
    logic       rstn, lock, sw;
    logic [3:0] rstn_o;
    logic       done, lost;
    logic       rstn1, lock1, sw1;
    logic [0:0] rstn_o1;
    logic       done1, lost1;

    int vectors;
    int miscompares;

    rst_seq_ctrl #(
        .NUM_OUT    (4),
        .HOLD_CYCLES(16),
        .STEP_CYCLES(8)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .pll_lock_i  (lock),
        .sw_rst_req_i(sw),
        .rstn_o      (rstn_o),
        .done_o      (done),
        .lock_lost_o (lost)
    );

    rst_seq_ctrl #(
        .NUM_OUT    (1),
        .HOLD_CYCLES(1),
        .STEP_CYCLES(1)
    ) dut1 (
        .clk_i       (clk),
        .rstn_i      (rstn1),
        .pll_lock_i  (lock1),
        .sw_rst_req_i(sw1),
        .rstn_o      (rstn_o1),
        .done_o      (done1),
        .lock_lost_o (lost1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] r, input logic d, input logic l);
        chk({tag, ".rstn"}, {28'd0, rstn_o}, {28'd0, r});
        chk({tag, ".done"}, {31'd0, done}, {31'd0, d});
        chk({tag, ".lost"}, {31'd0, lost}, {31'd0, l});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rstn  = 1'b0; lock  = 1'b1; sw  = 1'b0;
        rstn1 = 1'b0; lock1 = 1'b0; sw1 = 1'b0;

        // Reset state
        tick(2);
        chk_all("reset", 4'b0000, 1'b0, 1'b0);

        // Power-up with lock high: releases at edges 25/33/41/49 after reset release
        rstn = 1'b1;
        tick(24); chk_all("pu_e24", 4'b0000, 1'b0, 1'b0);
        tick(1);  chk_all("pu_e25", 4'b0001, 1'b0, 1'b0);
        tick(7);  chk_all("pu_e32", 4'b0001, 1'b0, 1'b0);
        tick(1);  chk_all("pu_e33", 4'b0011, 1'b0, 1'b0);
        tick(8);  chk_all("pu_e41", 4'b0111, 1'b0, 1'b0);
        tick(7);  chk_all("pu_e48", 4'b0111, 1'b0, 1'b0);
        tick(1);  chk_all("pu_e49", 4'b1111, 1'b1, 1'b0);

        // Software request held 5 cycles in DONE; lock_lost_o stays 0
        sw = 1'b1;
        tick(1);  chk_all("sw_first", 4'b0000, 1'b0, 1'b0);
        tick(4);  sw = 1'b0;
        tick(24); chk_all("sw_e24", 4'b0000, 1'b0, 1'b0);
        tick(1);  chk_all("sw_e25", 4'b0001, 1'b0, 1'b0);
        tick(24); chk_all("sw_e49", 4'b1111, 1'b1, 1'b0);

        // One-cycle lock drop in DONE
        lock = 1'b0;
        tick(1);  chk_all("ll_done", 4'b0000, 1'b0, 1'b1);
        lock = 1'b1;
        tick(24); chk_all("ll_e24", 4'b0000, 1'b0, 1'b1);
        tick(1);  chk_all("ll_e25", 4'b0001, 1'b0, 1'b1);
        tick(8);  chk_all("ll_e33", 4'b0011, 1'b0, 1'b1);

        // Lock drop mid-release at 0011: everything re-asserts, sequence restarts at bit 0
        lock = 1'b0;
        tick(1);  chk_all("ll_mid", 4'b0000, 1'b0, 1'b1);
        lock = 1'b1;
        tick(24); chk_all("mid_e24", 4'b0000, 1'b0, 1'b1);
        tick(1);  chk_all("mid_e25", 4'b0001, 1'b0, 1'b1);
        tick(16); chk_all("mid_e41", 4'b0111, 1'b0, 1'b1);

        // rstn_i pulse at 0111 with lock_lost_o set clears everything
        rstn = 1'b0;
        tick(1);  chk_all("rst_pulse", 4'b0000, 1'b0, 1'b0);
        rstn = 1'b1;
        tick(25); chk_all("rp_e25", 4'b0001, 1'b0, 1'b0);
        tick(24); chk_all("rp_e49", 4'b1111, 1'b1, 1'b0);

        // Lock arrives 100 cycles after WAIT_LOCK is entered
        lock = 1'b0;
        rstn = 1'b0;
        tick(1);
        rstn = 1'b1;
        tick(16);  chk_all("dl_wait", 4'b0000, 1'b0, 1'b0);
        tick(100); chk_all("dl_100", 4'b0000, 1'b0, 1'b0);
        lock = 1'b1;
        tick(8);   chk_all("dl_l7", 4'b0000, 1'b0, 1'b0);
        tick(1);   chk_all("dl_l8", 4'b0001, 1'b0, 1'b0);

        // Minimal configuration: NUM_OUT=1, HOLD=1, STEP=1
        rstn1 = 1'b1;
        tick(4);
        chk("min_wait.rstn", {31'd0, rstn_o1}, 32'd0);
        chk("min_wait.done", {31'd0, done1}, 32'd0);
        lock1 = 1'b1;
        tick(1);
        chk("min_e.rstn", {31'd0, rstn_o1}, 32'd0);
        tick(1);
        chk("min_e1.rstn", {31'd0, rstn_o1}, 32'd1);
        chk("min_e1.done", {31'd0, done1}, 32'd1);
        lock1 = 1'b0;
        tick(1);
        chk("min_ll.rstn", {31'd0, rstn_o1}, 32'd0);
        chk("min_ll.done", {31'd0, done1}, 32'd0);
        chk("min_ll.lost", {31'd0, lost1}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
